// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_pkg
// Desc     : Shared FSM encoding, AXI response codes and PROT default for the
//            AXI4-Lite command master.
// Revision : 1.0 - initial release
// ============================================================================
package axi_lite_pkg;

    typedef logic [1:0] resp_t;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_WR_REQ = 3'd1;
    localparam logic [2:0] c_ST_WAIT_B = 3'd2;
    localparam logic [2:0] c_ST_RD_REQ = 3'd3;
    localparam logic [2:0] c_ST_WAIT_R = 3'd4;
    localparam logic [2:0] c_ST_RSP    = 3'd5;

    localparam resp_t c_RESP_OKAY   = 2'b00;
    localparam resp_t c_RESP_SLVERR = 2'b10;

    localparam logic [2:0] c_PROT_DEFAULT = 3'b000;

endpackage
`default_nettype wire

// File: rtl/axi_lite_timeout.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_timeout
// Desc     : Response-wait counter; expired pulses on the TIMEOUT-th enabled
//            cycle after clear and the count then saturates.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_timeout #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] c_LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign expired = enable && (r_count == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/axi_lite_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_cmd_master
// Desc     : Converts single read/write commands into AXI4-Lite transactions
//            and returns one registered response per command, with timeout.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_cmd_master
    import axi_lite_pkg::*;
#(
    parameter int         ADDR_W  = 32,
    parameter int         DATA_W  = 32,
    parameter int         TIMEOUT = 256,
    parameter logic [2:0] PROT    = c_PROT_DEFAULT
) (
    input  logic                  ACLK,
    input  logic                  ARESET,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,

    output logic [ADDR_W-1:0]     M_AXI_AWADDR,
    output logic [2:0]            M_AXI_AWPROT,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [DATA_W-1:0]     M_AXI_WDATA,
    output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic [ADDR_W-1:0]     M_AXI_ARADDR,
    output logic [2:0]            M_AXI_ARPROT,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [DATA_W-1:0]     M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);

    logic [2:0]          r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic                r_awvalid;
    logic                r_wvalid;
    logic                r_bready;
    logic                r_arvalid;
    logic                r_rready;
    logic                r_rsp_valid;
    logic                r_rsp_write;
    logic [DATA_W-1:0]   r_rsp_rdata;
    resp_t               r_rsp_resp;
    logic                r_rsp_timeout;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_aw_done;
    logic w_w_done;
    logic w_in_wait;
    logic w_expired;

    assign w_aw_hs   = r_awvalid & M_AXI_AWREADY;
    assign w_w_hs    = r_wvalid  & M_AXI_WREADY;
    assign w_b_hs    = r_bready  & M_AXI_BVALID;
    assign w_ar_hs   = r_arvalid & M_AXI_ARREADY;
    assign w_r_hs    = r_rready  & M_AXI_RVALID;
    // A channel is done if it already handshook earlier or does so on this edge.
    assign w_aw_done = w_aw_hs | ~r_awvalid;
    assign w_w_done  = w_w_hs  | ~r_wvalid;
    assign w_in_wait = (r_state == c_ST_WAIT_B) || (r_state == c_ST_WAIT_R);

    axi_lite_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (ACLK),
        .rst     (ARESET),
        .clear   (~w_in_wait),
        .enable  (w_in_wait),
        .expired (w_expired)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state       <= c_ST_IDLE;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_write   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= c_RESP_OKAY;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (cmd_valid) begin
                        r_addr  <= cmd_addr;
                        r_wdata <= cmd_wdata;
                        r_wstrb <= cmd_wstrb;
                        if (cmd_write) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= c_ST_WR_REQ;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= c_ST_RD_REQ;
                        end
                    end
                end

                c_ST_WR_REQ: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= c_ST_WAIT_B;
                    end
                end

                c_ST_WAIT_B: begin
                    // A response on the expiry edge wins over the timeout.
                    if (w_b_hs) begin
                        r_bready      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_write   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_resp    <= M_AXI_BRESP;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= c_ST_RSP;
                    end else if (w_expired) begin
                        r_bready      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_write   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_resp    <= c_RESP_SLVERR;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= c_ST_RSP;
                    end
                end

                c_ST_RD_REQ: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= c_ST_WAIT_R;
                    end
                end

                c_ST_WAIT_R: begin
                    if (w_r_hs) begin
                        r_rready      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_write   <= 1'b0;
                        r_rsp_rdata   <= M_AXI_RDATA;
                        r_rsp_resp    <= M_AXI_RRESP;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= c_ST_RSP;
                    end else if (w_expired) begin
                        r_rready      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_write   <= 1'b0;
                        r_rsp_rdata   <= '0;
                        r_rsp_resp    <= c_RESP_SLVERR;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= c_ST_RSP;
                    end
                end

                c_ST_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = (r_state == c_ST_IDLE);

    assign rsp_valid     = r_rsp_valid;
    assign rsp_write     = r_rsp_write;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign rsp_timeout   = r_rsp_timeout;

    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWPROT  = PROT;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARPROT  = PROT;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule
`default_nettype wire
